ofdm_iq_input_buffer: RTL

Parametrised receive-side sample buffer sitting between the ADC/radio sample stream and `ofdm_frame_res`. Each accepted I/Q pair is scaled by a runtime arithmetic right shift, saturated to the output width, and stored in an on-chip circular FIFO. The downstream frame receiver pulls samples with a read request, matching `o_flag_wayt_data` / `!empty` semantics. The block also discards a programmable number of leading samples and counts overflow drops.

---
 rtl/ofdm_iq_input_buffer_if.sv | 34 +++
 rtl/ofdm_iq_input_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ofdm_iq_input_buffer_if.sv
// Sample-in / sample-out bundle of the OFDM receive input buffer.
// The master drives samples, configuration and read requests; the slave is the buffer.
interface ofdm_iq_input_buffer_if #(
  parameter int IN_SIZE    = 16,
  parameter int DATA_SIZE  = 16,
  parameter int DEPTH_LOG2 = 11
) ();
  logic                  i_restart;
  logic                  i_en;
  logic                  i_valid;
  logic [IN_SIZE-1:0]    i_data_i;
  logic [IN_SIZE-1:0]    i_data_q;
  logic [3:0]            i_shift;
  logic [15:0]           i_skip_cnt;
  logic                  i_rd_en;
  logic                  o_valid;
  logic [DATA_SIZE-1:0]  o_data_i;
  logic [DATA_SIZE-1:0]  o_data_q;
  logic                  o_empty;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_overflow;
  logic [15:0]           o_drop_cnt;

  modport master (
    output i_restart, i_en, i_valid, i_data_i, i_data_q, i_shift, i_skip_cnt, i_rd_en,
    input  o_valid, o_data_i, o_data_q, o_empty, o_full, o_count, o_overflow, o_drop_cnt
  );

  modport slave (
    input  i_restart, i_en, i_valid, i_data_i, i_data_q, i_shift, i_skip_cnt, i_rd_en,
    output o_valid, o_data_i, o_data_q, o_empty, o_full, o_count, o_overflow, o_drop_cnt
  );
endinterface

// File: rtl/ofdm_iq_input_buffer.sv
// Receive-side I/Q buffer: shift + saturate on write, circular FIFO, leading-sample skip,
// overflow drop counting. Reads return data two edges after the request (RAM + output reg).
//
//   state   | meaning
//   ST_SKIP | discarding leading samples until skip_ctr reaches i_skip_cnt
//   ST_RUN  | every qualified sample is offered to the FIFO
module ofdm_iq_input_buffer #(
  parameter int IN_SIZE    = 16,
  parameter int DATA_SIZE  = 16,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  ofdm_iq_input_buffer_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic signed [IN_SIZE-1:0] S_MAX =
    {{(IN_SIZE-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [IN_SIZE-1:0] S_MIN =
    {{(IN_SIZE-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic {ST_SKIP, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [15:0]             skip_ctr;
  logic                    w, skip_hit, skip_inc, store_req;
  logic                    wr_acc, rd_acc, drop;
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count_r, count_nxt;
  logic                    empty_r, full_r;
  logic                    overflow_r;
  logic [15:0]             drop_cnt_r;
  logic [2*DATA_SIZE-1:0]  mem [DEPTH];
  logic [2*DATA_SIZE-1:0]  rd_word;
  logic                    rd_pend;
  logic                    valid_r;
  logic [DATA_SIZE-1:0]    data_i_r, data_q_r;

  function automatic logic [DATA_SIZE-1:0] scale(input logic [IN_SIZE-1:0] x,
                                                 input logic [3:0] sh);
    logic signed [IN_SIZE-1:0] s;
    s = $signed(x) >>> sh;
    if (s > S_MAX)      return {1'b0, {(DATA_SIZE-1){1'b1}}};
    else if (s < S_MIN) return {1'b1, {(DATA_SIZE-1){1'b0}}};
    else                return s[DATA_SIZE-1:0];
  endfunction

  assign w = bus.i_en & bus.i_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)           state <= ST_SKIP;
    else if (bus.i_restart) state <= ST_SKIP;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_SKIP && w && skip_hit) state_nxt = ST_RUN;
  end

  always_comb begin
    skip_hit  = (skip_ctr == bus.i_skip_cnt);
    skip_inc  = 1'b0;
    store_req = 1'b0;
    case (state)
      ST_SKIP: begin
        if (w) begin
          if (skip_hit) store_req = 1'b1;
          else          skip_inc  = 1'b1;
        end
      end
      ST_RUN:  store_req = w;
      default: store_req = 1'b0;
    endcase
  end

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = bus.i_rd_en & ~empty_r;
  assign wr_acc = store_req & (~full_r | rd_acc);
  assign drop   = store_req & ~wr_acc;

  always_comb begin
    count_nxt = count_r;
    if (wr_acc && !rd_acc)      count_nxt = count_r + 1'b1;
    else if (rd_acc && !wr_acc) count_nxt = count_r - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      skip_ctr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else if (bus.i_restart) begin
      skip_ctr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      if (skip_inc) skip_ctr <= skip_ctr + 16'd1;
      if (wr_acc)   wr_ptr   <= wr_ptr + 1'b1;
      if (rd_acc)   rd_ptr   <= rd_ptr + 1'b1;
      count_r <= count_nxt;
      empty_r <= (count_nxt == '0);
      full_r  <= (count_nxt == COUNT_FULL);
      if (drop) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  // Storage has no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !bus.i_restart)
      mem[wr_ptr] <= {scale(bus.i_data_i, bus.i_shift), scale(bus.i_data_q, bus.i_shift)};
    if (rd_acc)
      rd_word <= mem[rd_ptr];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_pend  <= 1'b0;
      valid_r  <= 1'b0;
      data_i_r <= '0;
      data_q_r <= '0;
    end else if (bus.i_restart) begin
      rd_pend  <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      rd_pend <= rd_acc;
      valid_r <= rd_pend;
      if (rd_pend) begin
        data_i_r <= rd_word[2*DATA_SIZE-1:DATA_SIZE];
        data_q_r <= rd_word[DATA_SIZE-1:0];
      end
    end
  end

  assign bus.o_valid    = valid_r;
  assign bus.o_data_i   = data_i_r;
  assign bus.o_data_q   = data_q_r;
  assign bus.o_empty    = empty_r;
  assign bus.o_full     = full_r;
  assign bus.o_count    = count_r;
  assign bus.o_overflow = overflow_r;
  assign bus.o_drop_cnt = drop_cnt_r;

endmodule
